// File: rtl/riscv_ctl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control path:
// opcodes, funct fields, FSM states and the ALU operation selector.
package riscv_ctl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_I,
    WB,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    BRANCH,
    TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

endpackage

// File: rtl/alu_ctl_dec.sv
// ALU operation decoder: FSM-selected ALUop plus funct7[5] -> add/sub select.
module alu_ctl_dec
  import riscv_ctl_pkg::*;
(
  input  aluop_t aluop,
  input  logic   funct7_5,
  output logic   alu_ctl
);

  always_comb begin
    alu_ctl = 1'b0;
    unique case (aluop)
      ALUOP_ADD:   alu_ctl = 1'b0;
      ALUOP_SUB:   alu_ctl = 1'b1;
      ALUOP_FUNCT: alu_ctl = funct7_5;
      default:     alu_ctl = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencer for add/sub/addi/lw/sw/beq/bne: steps each instruction
// through fetch/decode/execute/memory/writeback and drives datapath strobes.
module multicycle_control
  import riscv_ctl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      im_data,
  input  logic             im_ready,
  input  logic             dm_ready,
  input  logic             ALUzero,
  output logic             im_req,
  output logic             dm_req,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             ALUsrc,
  output logic             ALUctl,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             PCWrite,
  output logic             PCsrc,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t state, next_state;
  instr_t ir;
  aluop_t aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      ir      <= '0;
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      state <= next_state;
      if (IRWrite) ir <= instr_t'(im_data);
      if (next_state == TRAP) illegal <= 1'b1;
      if (PCWrite) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      FETCH:  if (im_ready) next_state = DECODE;
      DECODE: begin
        next_state = TRAP;
        unique case (ir.opcode)
          OP_R:
            if ((ir.funct7 == F7_ADD || ir.funct7 == F7_SUB) && ir.funct3 == F3_ADD)
              next_state = EXEC_R;
          OP_I:
            if (ir.funct3 == F3_ADD) next_state = EXEC_I;
          OP_LOAD, OP_STORE:
            if (ir.funct3 == F3_W) next_state = MEM_ADDR;
          OP_BRANCH:
            if (ir.funct3 == F3_BEQ || ir.funct3 == F3_BNE) next_state = BRANCH;
          default: next_state = TRAP;
        endcase
      end
      EXEC_R:   next_state = WB;
      EXEC_I:   next_state = WB;
      WB:       next_state = FETCH;
      MEM_ADDR: next_state = (ir.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (dm_ready) next_state = FETCH;
      MEM_WR:   if (dm_ready) next_state = FETCH;
      BRANCH:   next_state = FETCH;
      TRAP:     next_state = TRAP;
      default:  next_state = FETCH;
    endcase
  end

  alu_ctl_dec u_alu_ctl_dec (
    .aluop    (aluop),
    .funct7_5 (ir.funct7[5]),
    .alu_ctl  (ALUctl)
  );

  // Everything is gated by rst_n so the reset state (FETCH) shows no request
  // until reset is released.
  always_comb begin
    im_req   = 1'b0;
    dm_req   = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    aluop    = ALUOP_ADD;
    MemtoReg = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    PCsrc    = 1'b0;
    if (rst_n) begin
      unique case (state)
        FETCH: begin
          im_req  = 1'b1;
          IRWrite = im_ready;
        end
        EXEC_R: aluop = ALUOP_FUNCT;
        EXEC_I: ALUsrc = 1'b1;
        WB: begin
          ALUsrc   = (ir.opcode == OP_I);
          aluop    = (ir.opcode == OP_R) ? ALUOP_FUNCT : ALUOP_ADD;
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
        end
        MEM_ADDR: ALUsrc = 1'b1;
        MEM_RD: begin
          dm_req   = 1'b1;
          ALUsrc   = 1'b1;
          RegWrite = dm_ready;
          MemtoReg = dm_ready;
          PCWrite  = dm_ready;
        end
        MEM_WR: begin
          dm_req   = 1'b1;
          ALUsrc   = 1'b1;
          MemWrite = 1'b1;
          PCWrite  = dm_ready;
        end
        BRANCH: begin
          aluop   = ALUOP_SUB;
          PCWrite = 1'b1;
          PCsrc   = ((ir.funct3 == F3_BEQ) &&  ALUzero) ||
                    ((ir.funct3 == F3_BNE) && !ALUzero);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected strobe vectors
// are queued as stimulus is applied and compared at the following negedge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] im_data = '0;
  logic        im_ready = 1'b0;
  logic        dm_ready = 1'b0;
  logic        ALUzero = 1'b0;
  logic        im_req, dm_req, IRWrite, RegWrite, ALUsrc, ALUctl;
  logic        MemtoReg, MemWrite, PCWrite, PCsrc, illegal;
  logic [31:0] instret;

  multicycle_control #(.CNT_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .im_data  (im_data),
    .im_ready (im_ready),
    .dm_ready (dm_ready),
    .ALUzero  (ALUzero),
    .im_req   (im_req),
    .dm_req   (dm_req),
    .IRWrite  (IRWrite),
    .RegWrite (RegWrite),
    .ALUsrc   (ALUsrc),
    .ALUctl   (ALUctl),
    .MemtoReg (MemtoReg),
    .MemWrite (MemWrite),
    .PCWrite  (PCWrite),
    .PCsrc    (PCsrc),
    .illegal  (illegal),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  // {im_req, dm_req, IRWrite, RegWrite, ALUsrc, ALUctl, MemtoReg, MemWrite, PCWrite, PCsrc, illegal}
  logic [10:0] obs;
  assign obs = {im_req, dm_req, IRWrite, RegWrite, ALUsrc, ALUctl,
                MemtoReg, MemWrite, PCWrite, PCsrc, illegal};

  localparam logic [10:0] V_ZERO     = 11'b000_0000_0000;
  localparam logic [10:0] V_FWAIT    = 11'b100_0000_0000;
  localparam logic [10:0] V_FRDY     = 11'b101_0000_0000;
  localparam logic [10:0] V_EX_SUB   = 11'b000_0010_0000;
  localparam logic [10:0] V_EX_I     = 11'b000_0100_0000;
  localparam logic [10:0] V_WB_ADD   = 11'b000_1000_0100;
  localparam logic [10:0] V_WB_SUB   = 11'b000_1010_0100;
  localparam logic [10:0] V_WB_I     = 11'b000_1100_0100;
  localparam logic [10:0] V_MADDR    = 11'b000_0100_0000;
  localparam logic [10:0] V_MRD_WAIT = 11'b010_0100_0000;
  localparam logic [10:0] V_MRD_DONE = 11'b010_1101_0100;
  localparam logic [10:0] V_MWR_WAIT = 11'b010_0100_1000;
  localparam logic [10:0] V_MWR_DONE = 11'b010_0100_1100;
  localparam logic [10:0] V_BR_T     = 11'b000_0010_0110;
  localparam logic [10:0] V_BR_N     = 11'b000_0010_0100;
  localparam logic [10:0] V_TRAP     = 11'b000_0000_0001;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_ADDI = 32'h40008093;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0050A623;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;

  typedef struct {
    logic [10:0] v;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [31:0] exp_cnt = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, want);
  endtask

  task automatic compare_head();
    exp_t x;
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      x = sb.pop_front();
      check(x.tag, {21'b0, obs}, {21'b0, x.v});
      check({x.tag, "_instret"}, instret, exp_cnt);
      if (x.v[2]) exp_cnt = exp_cnt + 1;
    end
  endtask

  // One clock cycle: drive inputs, queue the expected strobes, compare at negedge.
  task automatic cyc(input string tag, input logic [31:0] d, input logic imr,
                     input logic dmr, input logic az, input logic [10:0] e);
    exp_t x;
    im_data  = d;
    im_ready = imr;
    dm_ready = dmr;
    ALUzero  = az;
    x.v   = e;
    x.tag = tag;
    sb.push_back(x);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t r;
    // reset with im_ready high: nothing may be driven, not even im_req / IRWrite
    im_ready = 1'b1;
    r.v = V_ZERO; r.tag = "reset_outputs";
    sb.push_back(r);
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // add, immediate fetch
    cyc("add_fetch",  I_ADD, 1'b1, 1'b0, 1'b0, V_FRDY);
    cyc("add_decode", 32'h0, 1'b0, 1'b1, 1'b0, V_ZERO);
    cyc("add_exec",   32'h0, 1'b0, 1'b0, 1'b1, V_ZERO);
    cyc("add_wb",     32'h0, 1'b0, 1'b0, 1'b0, V_WB_ADD);

    // sub, fetch delayed three cycles; im_ready in decode is ignored
    cyc("sub_wait0",  I_SUB, 1'b0, 1'b0, 1'b0, V_FWAIT);
    cyc("sub_wait1",  I_SUB, 1'b0, 1'b0, 1'b0, V_FWAIT);
    cyc("sub_wait2",  I_SUB, 1'b0, 1'b0, 1'b0, V_FWAIT);
    cyc("sub_fetch",  I_SUB, 1'b1, 1'b0, 1'b0, V_FRDY);
    cyc("sub_decode", I_ADD, 1'b1, 1'b0, 1'b0, V_ZERO);
    cyc("sub_exec",   32'h0, 1'b1, 1'b0, 1'b0, V_EX_SUB);
    cyc("sub_wb",     32'h0, 1'b0, 1'b0, 1'b0, V_WB_SUB);

    // addi with bit 30 set still adds
    cyc("addi_fetch",  I_ADDI, 1'b1, 1'b0, 1'b0, V_FRDY);
    cyc("addi_decode", 32'h0,  1'b0, 1'b0, 1'b0, V_ZERO);
    cyc("addi_exec",   32'h0,  1'b0, 1'b0, 1'b0, V_EX_I);
    cyc("addi_wb",     32'h0,  1'b0, 1'b0, 1'b0, V_WB_I);

    // lw, dm_ready after two wait cycles
    cyc("lw_fetch",  I_LW,  1'b1, 1'b1, 1'b0, V_FRDY);
    cyc("lw_decode", 32'h0, 1'b0, 1'b0, 1'b0, V_ZERO);
    cyc("lw_addr",   32'h0, 1'b0, 1'b0, 1'b0, V_MADDR);
    cyc("lw_wait0",  32'h0, 1'b1, 1'b0, 1'b0, V_MRD_WAIT);
    cyc("lw_wait1",  32'h0, 1'b0, 1'b0, 1'b0, V_MRD_WAIT);
    cyc("lw_done",   32'h0, 1'b0, 1'b1, 1'b0, V_MRD_DONE);

    // sw, dm_ready immediate
    cyc("sw_fetch",  I_SW,  1'b1, 1'b0, 1'b0, V_FRDY);
    cyc("sw_decode", 32'h0, 1'b0, 1'b0, 1'b0, V_ZERO);
    cyc("sw_addr",   32'h0, 1'b0, 1'b0, 1'b0, V_MADDR);
    cyc("sw_done",   32'h0, 1'b0, 1'b1, 1'b0, V_MWR_DONE);

    // branches, both ALUzero polarities
    cyc("beq_t_fetch",  I_BEQ, 1'b1, 1'b0, 1'b0, V_FRDY);
    cyc("beq_t_decode", 32'h0, 1'b0, 1'b0, 1'b0, V_ZERO);
    cyc("beq_t_branch", 32'h0, 1'b0, 1'b0, 1'b1, V_BR_T);
    cyc("beq_n_fetch",  I_BEQ, 1'b1, 1'b0, 1'b1, V_FRDY);
    cyc("beq_n_decode", 32'h0, 1'b0, 1'b0, 1'b1, V_ZERO);
    cyc("beq_n_branch", 32'h0, 1'b0, 1'b0, 1'b0, V_BR_N);
    cyc("bne_z_fetch",  I_BNE, 1'b1, 1'b0, 1'b0, V_FRDY);
    cyc("bne_z_decode", 32'h0, 1'b0, 1'b0, 1'b0, V_ZERO);
    cyc("bne_z_branch", 32'h0, 1'b0, 1'b0, 1'b1, V_BR_N);
    cyc("bne_nz_fetch", I_BNE, 1'b1, 1'b0, 1'b1, V_FRDY);
    cyc("bne_nz_decode",32'h0, 1'b0, 1'b0, 1'b1, V_ZERO);
    cyc("bne_nz_branch",32'h0, 1'b0, 1'b0, 1'b0, V_BR_T);

    // sw stalled in memory, then reset mid-wait
    cyc("swr_fetch",  I_SW,  1'b1, 1'b0, 1'b0, V_FRDY);
    cyc("swr_decode", 32'h0, 1'b0, 1'b0, 1'b0, V_ZERO);
    cyc("swr_addr",   32'h0, 1'b0, 1'b0, 1'b0, V_MADDR);
    cyc("swr_wait0",  32'h0, 1'b0, 1'b0, 1'b0, V_MWR_WAIT);
    cyc("swr_wait1",  32'h0, 1'b0, 1'b0, 1'b0, V_MWR_WAIT);
    rst_n = 1'b0;
    dm_ready = 1'b1;
    #1;
    exp_cnt = '0;
    r.v = V_ZERO; r.tag = "swr_reset";
    sb.push_back(r);
    compare_head();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_reset_fetch", 32'h0, 1'b0, 1'b1, 1'b0, V_FWAIT);

    // illegal instruction traps and stays
    cyc("trap_fetch",  32'h0, 1'b1, 1'b0, 1'b0, V_FRDY);
    cyc("trap_decode", 32'h0, 1'b0, 1'b0, 1'b0, V_ZERO);
    cyc("trap_0",      I_ADD, 1'b1, 1'b1, 1'b0, V_TRAP);
    cyc("trap_1",      I_ADD, 1'b1, 1'b0, 1'b1, V_TRAP);
    cyc("trap_2",      32'h0, 1'b0, 1'b1, 1'b0, V_TRAP);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
